// File: rtl/pipe_controller.sv
// rtl/pipe_controller.sv - registered ID/EX main decoder with bubble insertion and halt drain FSM
module pipe_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter bit EN_JUMP      = 1'b1,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       id_valid,
  input  logic [6:0] Opcode,
  input  logic       stall,
  input  logic       flush,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] ALUOp,
  output logic       Branch,
  output logic       Jump,
  output logic       JalrSel,
  output logic       LinkSel,
  output logic       illegal_op,
  output logic       fetch_stop,
  output logic       halted
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_NOP  = 7'b0000000;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic       d_alusrc, d_memtoreg, d_regwrite, d_memread, d_memwrite;
  logic [1:0] d_aluop;
  logic       d_branch, d_jump, d_jalrsel, d_linksel;
  logic       d_illegal, d_halt;
  logic       accept;

  assign accept = id_valid & ~stall & ~flush & (state == RUN);

  // Combinational opcode decode; only consumed when the instruction is accepted.
  always_comb begin
    d_alusrc   = 1'b0;
    d_memtoreg = 1'b0;
    d_regwrite = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_aluop    = 2'b00;
    d_branch   = 1'b0;
    d_jump     = 1'b0;
    d_jalrsel  = 1'b0;
    d_linksel  = 1'b0;
    d_illegal  = 1'b0;
    d_halt     = 1'b0;
    case (Opcode)
      OP_R: begin
        d_regwrite = 1'b1;
        d_aluop    = 2'b10;
      end
      OP_I: begin
        d_alusrc   = 1'b1;
        d_regwrite = 1'b1;
        d_aluop    = 2'b11;
      end
      OP_LW: begin
        d_alusrc   = 1'b1;
        d_memtoreg = 1'b1;
        d_regwrite = 1'b1;
        d_memread  = 1'b1;
      end
      OP_SW: begin
        d_alusrc   = 1'b1;
        d_memwrite = 1'b1;
      end
      OP_BR: begin
        d_branch = 1'b1;
        d_aluop  = 2'b01;
      end
      OP_JAL: begin
        if (EN_JUMP) begin
          d_jump     = 1'b1;
          d_regwrite = 1'b1;
          d_linksel  = 1'b1;
        end else begin
          d_illegal = 1'b1;
        end
      end
      OP_JALR: begin
        if (EN_JUMP) begin
          d_jump     = 1'b1;
          d_jalrsel  = 1'b1;
          d_alusrc   = 1'b1;
          d_regwrite = 1'b1;
          d_linksel  = 1'b1;
        end else begin
          d_illegal = 1'b1;
        end
      end
      OP_NOP:  ;
      OP_HALT: d_halt = 1'b1;
      default: d_illegal = 1'b1;
    endcase
  end

  // Drain FSM and the registered ID/EX control bundle; a bubble is the default every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      cnt        <= '0;
      ALUSrc     <= 1'b0;
      MemtoReg   <= 1'b0;
      RegWrite   <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      ALUOp      <= 2'b00;
      Branch     <= 1'b0;
      Jump       <= 1'b0;
      JalrSel    <= 1'b0;
      LinkSel    <= 1'b0;
      illegal_op <= 1'b0;
      fetch_stop <= 1'b0;
      halted     <= 1'b0;
    end else begin
      ALUSrc     <= 1'b0;
      MemtoReg   <= 1'b0;
      RegWrite   <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      ALUOp      <= 2'b00;
      Branch     <= 1'b0;
      Jump       <= 1'b0;
      JalrSel    <= 1'b0;
      LinkSel    <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            ALUSrc     <= d_alusrc;
            MemtoReg   <= d_memtoreg;
            RegWrite   <= d_regwrite;
            MemRead    <= d_memread;
            MemWrite   <= d_memwrite;
            ALUOp      <= d_aluop;
            Branch     <= d_branch;
            Jump       <= d_jump;
            JalrSel    <= d_jalrsel;
            LinkSel    <= d_linksel;
            illegal_op <= d_illegal;
            if (d_halt) begin
              state      <= DRAIN;
              cnt        <= CNT_W'(DRAIN_CYCLES - 1);
              fetch_stop <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // The counter hits zero in the last cycle in which EX/MEM/WB still hold work.
          if (cnt == '0) begin
            state <= HALTED;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule
